pmu_evt_tx_c910: RTL and testbench
==================================

// Module: pmu_evt_tx_c910
// PURPOSE
//  - Transmit end of the PMU fast->slow event crossing, in the fast_clk domain.
//  - Counts single-cycle event pulses on evt_in.
//  - Sends each event to the slow domain as one 4-phase req/ack transfer.
//  - ack_in arrives asynchronously from the slow domain and is synchronised here.
//  - Queued events are never merged; only counter saturation loses events, and that is flagged.
// PARAMETERS
//  CNT_W        4    width of pending-event counter; saturates at 2**CNT_W-1
//  SYNC_STAGES  2    flop stages on ack_in (legal 2..4)
//  TIMEOUT_CYC  255  fast_clk cycles allowed in REQ before abort (timeout build only)
// PORTS
//  fast_clk       in   1      single clock
//  pad_cpu_rst_b  in   1      asynchronous active-low reset
//  evt_in         in   1      event pulse; each high cycle = one event
//  ack_in         in   1      async ack level from slow-domain receiver
//  ovf_clr        in   1      clears ovf (and timeout_err when built in)
//  req_out        out  1      request level to slow domain; registered, glitch-free
//  pend_cnt       out  CNT_W  events queued, not yet started
//  busy           out  1      FSM not IDLE
//  ovf            out  1      sticky: event lost at counter saturation
//  timeout_err    out  1      sticky abort flag (timeout build only)
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM=IDLE; all outputs 0; sync flops 0; counters 0.
//  - ack_s: ack_in delayed through SYNC_STAGES flops. Only ack_s is used by logic.
//  - Counter, one update per cycle:
//    - inc = evt_in; dec = (IDLE and pend_cnt!=0).
//    - inc&dec -> hold. inc only -> +1. dec only -> -1.
//    - inc only at max -> hold and set ovf. ovf stays set until ovf_clr.
//    - ovf_clr and a new overflow in the same cycle -> ovf=1 (set wins).
//  - FSM:
//    - IDLE: pend_cnt!=0 -> REQ, req_out<=1, pend_cnt decremented.
//    - REQ: ack_s==1 -> WAIT, req_out<=0.
//    - WAIT: ack_s==0 -> IDLE.
//  - No new req rises until ack_s is seen low (full 4-phase completes).
//  - Latency, idle and empty:
//    - evt_in high in cycle 0 -> pend_cnt=1 after edge 0.
//    - req_out=1 and pend_cnt=0 after edge 1.
//  - Back-to-back transfers: IDLE lasts exactly 1 cycle between WAIT exit and next REQ.
//  - busy = (state != IDLE), registered alongside the FSM state.
//  - Events during REQ/WAIT only increment pend_cnt. The transfer in flight is unaffected.
//  - ack_s high while in IDLE (spurious/stale): ignored. A REQ entered while ack_s=1 advances to WAIT the next cycle.
//  - Reset mid-transfer: req_out drops immediately (async). The slow side must tolerate the aborted handshake.
// CONFIGURATION
//  - Macro PMU_EVT_TX_TIMEOUT_EN.
//  - Defined:
//    - An 8+ bit counter runs in REQ; it is cleared on REQ entry.
//    - After TIMEOUT_CYC cycles in REQ with ack_s still 0: req_out<=0, go to WAIT, set timeout_err.
//    - The aborted event is not re-queued.
//    - timeout_err is cleared by ovf_clr.
//  - Undefined:
//    - No timeout counter; REQ waits indefinitely.
//    - timeout_err port is absent.
// TESTING
//  1. Reset with evt_in=1 and ack_in=1 -> all outputs 0; after release, pend_cnt=1 one edge after the first sampled evt_in.
//  2. Single evt_in pulse; slow model acks 3 cycles after req and drops ack 3 cycles after req falls:
//     -> req_out high exactly once; busy falls SYNC_STAGES+1 cycles after ack drops.
//  3. Five evt_in pulses while the first transfer is in REQ:
//     -> pend_cnt=5; exactly 6 req rising edges total; pend_cnt ends 0; ovf=0.
//  4. 20 consecutive evt_in cycles with ack held 0 (CNT_W=4):
//     -> pend_cnt sticks at 15; ovf=1. ovf_clr -> ovf=0, pend_cnt unchanged.
//  5. evt_in high in the same cycle the FSM leaves IDLE with pend_cnt=1 -> pend_cnt stays 1.
//  6. PMU_EVT_TX_TIMEOUT_EN, TIMEOUT_CYC=10, ack never returns:
//     -> req_out falls after 10 REQ cycles; timeout_err=1; FSM goes IDLE once ack_s=0.

Source files
------------

// File: rtl/pmu_evt_tx_c910.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pmu_evt_tx_c910
// Brief    : PMU fast->slow event crossing, transmit side. Counts event pulses
//            and sends each one as a 4-phase req/ack transfer. Optional REQ
//            timeout enabled by macro PMU_EVT_TX_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module pmu_evt_tx_c910 #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
`ifdef PMU_EVT_TX_TIMEOUT_EN
  ,parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic             fast_clk,
  input  logic             pad_cpu_rst_b,
  input  logic             evt_in,
  input  logic             ack_in,
  input  logic             ovf_clr,
  output logic             req_out,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             busy,
  output logic             ovf
`ifdef PMU_EVT_TX_TIMEOUT_EN
  ,output logic            timeout_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t                 r_state;
  logic                   r_req;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_pend;
  logic                   r_ovf;
  logic [SYNC_STAGES-1:0] r_ack_sync;

  logic w_ack_s;
  logic w_inc;
  logic w_dec;
  logic w_sat;

  always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // The decrement is the event being handed to the FSM as it leaves IDLE.
  assign w_inc = evt_in;
  assign w_dec = (r_state == ST_IDLE) && (r_pend != '0);
  assign w_sat = w_inc && !w_dec && (r_pend == c_cnt_max);

  always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_inc && !w_dec && !w_sat) begin
        r_pend <= r_pend + 1'b1;
      end else if (!w_inc && w_dec) begin
        r_pend <= r_pend - 1'b1;
      end
      if (w_sat) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef PMU_EVT_TX_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_terr;
  logic            w_to_fire;

  assign w_to_fire = (r_state == ST_REQ) && !w_ack_s && (r_to_cnt == c_to_last);

  always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_terr <= 1'b0;
    end else if (w_to_fire) begin
      r_terr <= 1'b1;
    end else if (ovf_clr) begin
      r_terr <= 1'b0;
    end
  end

  assign timeout_err = r_terr;
`endif

  always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_state  <= ST_IDLE;
      r_req    <= 1'b0;
      r_busy   <= 1'b0;
`ifdef PMU_EVT_TX_TIMEOUT_EN
      r_to_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pend != '0) begin
            r_state  <= ST_REQ;
            r_req    <= 1'b1;
            r_busy   <= 1'b1;
`ifdef PMU_EVT_TX_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (w_ack_s) begin
            r_state <= ST_WAIT;
            r_req   <= 1'b0;
          end
`ifdef PMU_EVT_TX_TIMEOUT_EN
          // Abandon the transfer; the event is dropped, not re-queued.
          else if (w_to_fire) begin
            r_state <= ST_WAIT;
            r_req   <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        ST_WAIT: begin
          if (!w_ack_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_out  = r_req;
  assign pend_cnt = r_pend;
  assign busy     = r_busy;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pmu_evt_tx_c910.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pmu_evt_tx_c910
// Brief    : Directed and randomized bench for pmu_evt_tx_c910 against a
//            cycle-level event/handshake reference model.
// Revision : 1.0
// ============================================================================
module tb_pmu_evt_tx_c910;

  localparam int CNT_W = 4;
  localparam int SS    = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PMU_EVT_TX_TIMEOUT_EN
  localparam int TO_CYC = 10;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             evt   = 1'b0;
  logic             ack   = 1'b0;
  logic             clr   = 1'b0;
  logic             req;
  logic [CNT_W-1:0] pend;
  logic             busy;
  logic             ovf;
`ifdef PMU_EVT_TX_TIMEOUT_EN
  logic             terr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pmu_evt_tx_c910 #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SS)
`ifdef PMU_EVT_TX_TIMEOUT_EN
    ,.TIMEOUT_CYC (TO_CYC)
`endif
  ) u_dut (
    .fast_clk      (clk),
    .pad_cpu_rst_b (rst_n),
    .evt_in        (evt),
    .ack_in        (ack),
    .ovf_clr       (clr),
    .req_out       (req),
    .pend_cnt      (pend),
    .busy          (busy),
    .ovf           (ovf)
`ifdef PMU_EVT_TX_TIMEOUT_EN
    ,.timeout_err  (terr)
`endif
  );

  // Reference model: event queue depth, transfer-in-flight, request level.
  int m_pend;
  bit m_ovf;
  bit m_inflight;
  bit m_req;
  bit m_sync [SS];
`ifdef PMU_EVT_TX_TIMEOUT_EN
  bit m_terr;
  int m_req_cyc;
`endif

  // Slow-side responder and observation state.
  bit resp_en = 1'b0;
  int dly     = 3;
  int hi_cnt  = 0;
  int lo_cnt  = 0;
  bit prev_req = 1'b0;
  int rises   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend     = 0;
    m_ovf      = 1'b0;
    m_inflight = 1'b0;
    m_req      = 1'b0;
    for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
`ifdef PMU_EVT_TX_TIMEOUT_EN
    m_terr    = 1'b0;
    m_req_cyc = 0;
`endif
  endtask

  task automatic model_edge();
    bit ack_s;
    bit take;
    bit lost;
`ifdef PMU_EVT_TX_TIMEOUT_EN
    bit to_hit;
    to_hit = 1'b0;
`endif
    ack_s = m_sync[SS-1];
    take  = !m_inflight && (m_pend != 0);
    lost  = 1'b0;
    if (!m_inflight) begin
      if (m_pend != 0) begin
        m_inflight = 1'b1;
        m_req      = 1'b1;
`ifdef PMU_EVT_TX_TIMEOUT_EN
        m_req_cyc  = 0;
`endif
      end
    end else if (m_req) begin
      if (ack_s) m_req = 1'b0;
`ifdef PMU_EVT_TX_TIMEOUT_EN
      else begin
        m_req_cyc++;
        if (m_req_cyc == TO_CYC) begin
          m_req  = 1'b0;
          to_hit = 1'b1;
        end
      end
`endif
    end else if (!ack_s) begin
      m_inflight = 1'b0;
    end
    if (evt && !take) begin
      if (m_pend == CMAX) lost = 1'b1;
      else m_pend++;
    end else if (!evt && take) begin
      m_pend--;
    end
    if (lost) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
`ifdef PMU_EVT_TX_TIMEOUT_EN
    if (to_hit) m_terr = 1'b1;
    else if (clr) m_terr = 1'b0;
`endif
    for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = ack;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("req_out", req, m_req);
    check("pend_cnt", pend, m_pend);
    check("busy", busy, m_inflight);
    check("ovf", ovf, m_ovf);
`ifdef PMU_EVT_TX_TIMEOUT_EN
    check("timeout_err", terr, m_terr);
`endif
    if (req && !prev_req) rises++;
    prev_req = req;
    if (resp_en) begin
      if (req) begin
        lo_cnt = 0;
        if (hi_cnt >= dly) ack = 1'b1;
        hi_cnt++;
      end else begin
        hi_cnt = 0;
        if (lo_cnt >= dly) ack = 1'b0;
        lo_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    evt = 1'b1;
    ack = 1'b1;
    clr = 1'b0;
    resp_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", req, 0);
    check("rst_pend", pend, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
`ifdef PMU_EVT_TX_TIMEOUT_EN
    check("rst_terr", terr, 0);
`endif
    hi_cnt = 0;
    lo_cnt = 0;
    prev_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    evt = 1'b0;
    clr = 1'b0;
    resp_en = 1'b1;
    n = 0;
    while ((busy || pend != 0 || ack) && n < 3000) begin
      step();
      n++;
    end
    check("drain_done", (n < 3000) ? 1 : 0, 1);
  endtask

  initial begin
    int t_drop;
    int t_busy;
    int n;
    model_reset();

    // Reset with evt/ack high; first sampled event shows up one edge later.
    do_reset();
    step();
    check("t1_first_evt", pend, 1);
    evt = 1'b0;
    ack = 1'b0;
    drain();

    // Single event, slow side acks after 3 cycles and releases after 3.
    dly = 3;
    rises = 0;
    evt = 1'b1;
    step();
    evt = 1'b0;
    resp_en = 1'b1;
    t_drop = -1;
    t_busy = -1;
    n = 0;
    while (t_busy < 0 && n < 100) begin
      bit a0;
      a0 = ack;
      step();
      n++;
      if (a0 && !ack) t_drop = n;
      if (t_drop >= 0 && n > t_drop && !busy) t_busy = n;
    end
    check("t2_done", (t_busy >= 0) ? 1 : 0, 1);
    check("t2_busy_lat", t_busy - t_drop, SS + 1);
    check("t2_req_once", rises, 1);
    drain();

    // Five events queued while the first transfer sits in REQ.
    rises = 0;
    resp_en = 1'b0;
    ack = 1'b0;
    evt = 1'b1;
    step();
    evt = 1'b0;
    n = 0;
    while (!req && n < 10) begin
      step();
      n++;
    end
    check("t3_in_req", req, 1);
    evt = 1'b1;
    repeat (5) step();
    evt = 1'b0;
    check("t3_pend5", pend, 5);
    drain();
    check("t3_rises", rises, 6);
    check("t3_pend0", pend, 0);
    check("t3_ovf0", ovf, 0);

    // Event arriving as the FSM takes the last queued event.
    evt = 1'b1;
    step();
    check("t5_pend1a", pend, 1);
    step();
    check("t5_pend1b", pend, 1);
    drain();

    // Saturation with ack held low.
    resp_en = 1'b0;
    ack = 1'b0;
    evt = 1'b1;
    repeat (20) step();
    evt = 1'b0;
`ifndef PMU_EVT_TX_TIMEOUT_EN
    check("t4_sat", pend, CMAX);
    check("t4_ovf", ovf, 1);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t4_ovf_clr", ovf, 0);
`ifndef PMU_EVT_TX_TIMEOUT_EN
    check("t4_pend_kept", pend, CMAX);
`endif
    drain();

    // Reset in the middle of a transfer drops req asynchronously.
    evt = 1'b1;
    step();
    evt = 1'b0;
    step();
    check("mid_in_req", req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_req_drop", req, 0);
    check("mid_busy_drop", busy, 0);
    do_reset();
    evt = 1'b0;
    ack = 1'b0;
    drain();

    // Randomized traffic: well-behaved responder and chaotic ack levels.
    for (int blk = 0; blk < 6; blk++) begin
      int rate;
      int mode;
      mode = blk % 3;
      rate = (mode == 2) ? 80 : 30;
      dly = $urandom_range(4, 0);
      resp_en = (mode != 1);
      for (int c = 0; c < 400; c++) begin
        evt = ($urandom_range(99, 0) < rate);
        clr = ($urandom_range(99, 0) < 5);
        if (mode == 1) ack = $urandom_range(1, 0);
        step();
      end
    end
    drain();

`ifdef PMU_EVT_TX_TIMEOUT_EN
    // Ack never returns: abort after TO_CYC cycles in REQ.
    resp_en = 1'b0;
    ack = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    evt = 1'b1;
    step();
    evt = 1'b0;
    n = 0;
    while (!req && n < 10) begin
      step();
      n++;
    end
    n = 0;
    while (req && n < 50) begin
      n++;
      step();
    end
    check("t6_req_cycles", n, TO_CYC);
    check("t6_terr", terr, 1);
    step();
    check("t6_idle", busy, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t6_terr_clr", terr, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
